// File: rtl/key_step_pkg.sv
// Shared types for the key_step_gen pushbutton step generator.
package key_step_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRESS_DB   = 3'd1,
    ST_HELD       = 3'd2,
    ST_REPEAT     = 3'd3,
    ST_RELEASE_DB = 3'd4
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == '1) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous level input, resets to 0.
module sync2 (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/key_step_gen.sv
// Debounced pushbutton to single-cycle step pulses, optional auto-repeat.
// Auto-repeat is enabled by defining KEY_STEP_AUTOREPEAT_EN.
module key_step_gen
  import key_step_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned RPT_DELAY  = 16,
  parameter int unsigned RPT_PERIOD = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_n,
  input  logic en,
  output logic step,
  output logic pressed,
  output logic rpt_active
);

`ifdef KEY_STEP_AUTOREPEAT_EN
  localparam bit L_AUTO = 1'b1;
`else
  localparam bit L_AUTO = 1'b0;
`endif

  // Limits are "last count value": the current sample completes the run.
  localparam logic [CNT_W-1:0] L_DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_DLY_LAST = CNT_W'(RPT_DELAY - 1);
  localparam logic [CNT_W-1:0] L_PER_LAST = CNT_W'(RPT_PERIOD - 1);
  localparam bit               L_DEB_ONE  = (DEB_CYCLES == 1);
  localparam logic [CNT_W-1:0] L_ONE      = CNT_W'(1);

  logic             w_key_raw;
  logic             w_key_s;
  state_e           r_state;
  state_e           w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_step_nxt;
  logic             r_step;
  logic             r_pressed;
  logic             r_rpt;

  assign w_key_raw = ~key_n;

  sync2 u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (w_key_raw),
    .q    (w_key_s)
  );

  always_comb begin
    w_nxt      = r_state;
    w_cnt_nxt  = r_cnt;
    w_step_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_key_s) begin
          if (L_DEB_ONE) begin
            w_nxt      = ST_HELD;
            w_step_nxt = en;
          end else begin
            w_nxt     = ST_PRESS_DB;
            w_cnt_nxt = L_ONE;
          end
        end
      end
      ST_PRESS_DB: begin
        if (!w_key_s) begin
          w_nxt     = ST_IDLE;
          w_cnt_nxt = '0;
        end else if (r_cnt >= L_DEB_LAST) begin
          w_nxt      = ST_HELD;
          w_cnt_nxt  = '0;
          w_step_nxt = en;
        end else begin
          w_cnt_nxt = sat_inc(r_cnt);
        end
      end
      ST_HELD, ST_REPEAT: begin
        // Release is checked first so it wins over a coincident repeat.
        if (!w_key_s) begin
          w_nxt     = L_DEB_ONE ? ST_IDLE : ST_RELEASE_DB;
          w_cnt_nxt = L_DEB_ONE ? '0 : L_ONE;
        end else if (r_state == ST_HELD) begin
          if (L_AUTO && r_cnt >= L_DLY_LAST) begin
            w_nxt      = ST_REPEAT;
            w_cnt_nxt  = '0;
            w_step_nxt = en;
          end else begin
            w_cnt_nxt = L_AUTO ? sat_inc(r_cnt) : '0;
          end
        end else if (r_cnt >= L_PER_LAST) begin
          w_cnt_nxt  = '0;
          w_step_nxt = en;
        end else begin
          w_cnt_nxt = sat_inc(r_cnt);
        end
      end
      ST_RELEASE_DB: begin
        if (w_key_s) begin
          w_nxt     = ST_HELD;
          w_cnt_nxt = '0;
        end else if (r_cnt >= L_DEB_LAST) begin
          w_nxt     = ST_IDLE;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = sat_inc(r_cnt);
        end
      end
      default: begin
        w_nxt     = ST_IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_step    <= 1'b0;
      r_pressed <= 1'b0;
      r_rpt     <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_cnt     <= w_cnt_nxt;
      r_step    <= w_step_nxt;
      r_pressed <= (w_nxt == ST_HELD) || (w_nxt == ST_REPEAT) ||
                   (w_nxt == ST_RELEASE_DB);
      r_rpt     <= L_AUTO && (w_nxt == ST_REPEAT);
    end
  end

  assign step       = r_step;
  assign pressed    = r_pressed;
  assign rpt_active = r_rpt;

endmodule

// File: tb/tb_key_step_gen.sv
// Bench for key_step_gen: directed timing pins plus randomized key traffic.
// Honours KEY_STEP_AUTOREPEAT_EN the same way as the design.
module tb_key_step_gen;

  localparam int DEB = 4;
  localparam int DLY = 16;
  localparam int PER = 4;
`ifdef KEY_STEP_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic key_n = 1'b1;
  logic en = 1'b1;
  logic step;
  logic pressed;
  logic rpt_active;

  int checks = 0;
  int errs = 0;

  key_step_gen #(
    .DEB_CYCLES (DEB),
    .RPT_DELAY  (DLY),
    .RPT_PERIOD (PER)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .key_n      (key_n),
    .en         (en),
    .step       (step),
    .pressed    (pressed),
    .rpt_active (rpt_active)
  );

  always #5 clk = ~clk;

  // Behavioural model: accepted level, run of disagreeing samples,
  // and a timer since the last step / start of hold.
  bit m_s1 = 0, m_s2 = 0, m_s = 0;
  bit m_acc = 0, m_rep = 0, m_step = 0;
  int m_run = 0, m_t = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_s1 = 0; m_s2 = 0; m_acc = 0; m_rep = 0;
      m_step = 0; m_run = 0; m_t = 0;
    end else begin
      m_s = m_s2;
      m_s2 = m_s1;
      m_s1 = !key_n;
      m_step = 0;
      if (!m_acc) begin
        if (m_s) begin
          m_run++;
          if (m_run >= DEB) begin
            m_acc = 1; m_run = 0; m_rep = 0; m_t = 0;
            m_step = en;
          end
        end else m_run = 0;
      end else if (!m_s) begin
        m_run++;
        if (m_run >= DEB) begin
          m_acc = 0; m_run = 0; m_rep = 0;
        end
      end else if (m_run > 0) begin
        m_run = 0; m_rep = 0; m_t = 0;
      end else if (AUTO) begin
        m_t++;
        if (m_t == (m_rep ? PER : DLY)) begin
          m_step = en; m_rep = 1; m_t = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %b expected %b at %0t", nm, a, e, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  always @(negedge clk) begin
    chk("step", step, m_step);
    chk("pressed", pressed, m_acc);
    chk("rpt_active", rpt_active, m_acc && m_rep && (m_run == 0));
  end

  int q_steps[$];
  int first_pr;
  int first_rpt;
  bit pr_drop;

  function automatic int qat(input int i);
    return (i < q_steps.size()) ? q_steps[i] : -1;
  endfunction

  // Key low from edge 1; optional high bounce window; released after n.
  task automatic hold_run(input int n, input int span,
                          input int hi_from, input int hi_len);
    q_steps.delete();
    first_pr = -1;
    first_rpt = -1;
    pr_drop = 0;
    @(negedge clk);
    key_n = 1'b0;
    for (int e = 1; e <= span; e++) begin
      @(posedge clk);
      #1;
      if (step) q_steps.push_back(e);
      if (pressed && first_pr < 0) first_pr = e;
      if (rpt_active && first_rpt < 0) first_rpt = e;
      if (first_pr >= 0 && e < n && !pressed) pr_drop = 1;
      key_n = (e >= n) || (e + 1 >= hi_from && e + 1 < hi_from + hi_len);
    end
    key_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_step", step, 1'b0);
    chk("reset_pressed", pressed, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    hold_run(3, 15, 0, 0);
    chk_int("glitch_steps", q_steps.size(), 0);
    chk_int("glitch_pressed", first_pr, -1);

    hold_run(10, 25, 0, 0);
    chk_int("short_nsteps", q_steps.size(), 1);
    chk_int("short_step_edge", qat(0), 6);
    chk_int("short_pressed_edge", first_pr, 6);

    en = 1'b0;
    hold_run(10, 25, 0, 0);
    en = 1'b1;
    chk_int("en0_steps", q_steps.size(), 0);
    chk_int("en0_pressed_edge", first_pr, 6);

    hold_run(40, 50, 0, 0);
    chk_int("long_step0", qat(0), 6);
    if (AUTO) begin
      chk_int("long_step1", qat(1), 22);
      chk_int("long_step2", qat(2), 26);
      chk_int("long_step3", qat(3), 30);
      chk_int("long_step4", qat(4), 34);
      chk_int("long_step5", qat(5), 38);
      chk_int("long_rpt_edge", first_rpt, 22);
    end else begin
      chk_int("long_nsteps", q_steps.size(), 1);
      chk_int("long_rpt_edge", first_rpt, -1);
    end

    hold_run(60, 70, 25, 2);
    chk_int("bounce_pr_drop", int'(pr_drop), 0);
    chk_int("bounce_step0", qat(0), 6);
    if (AUTO) begin
      chk_int("bounce_step2", qat(2), 26);
      chk_int("bounce_step3", qat(3), 45);
    end else begin
      chk_int("bounce_nsteps", q_steps.size(), 1);
    end

    @(negedge clk);
    key_n = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_pre_pressed", pressed, 1'b1);
    #1 rstn = 1'b0;
    #1;
    chk("rst_step", step, 1'b0);
    chk("rst_pressed", pressed, 1'b0);
    chk("rst_rpt", rpt_active, 1'b0);
    @(negedge clk);
    #2 rstn = 1'b1;
    q_steps.delete();
    for (int e = 21; e <= 30; e++) begin
      @(posedge clk);
      #1;
      if (step) q_steps.push_back(e);
    end
    chk_int("rst_next_step", qat(0), 26);
    key_n = 1'b1;
    repeat (12) @(negedge clk);

    for (int c = 0; c < 4000; c++) begin
      int p;
      @(negedge clk);
      p = ((c / 200) % 2 == 0) ? 2 : 25;
      if ($urandom_range(0, 99) < p) key_n = ~key_n;
      if ($urandom_range(0, 99) < 3) en = ~en;
      if ($urandom_range(0, 999) < 3) begin
        #3 rstn = 1'b0;
        @(negedge clk);
        #3 rstn = 1'b1;
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
